sort_pipe: RTL and testbench

- Parametrised, pipelined bitonic sorting network for N (key, tag) entries; the next generation of our 4-input combinational comparator sorter.
- Adds a register per comparator stage, valid/ready flow control with backpressure, a per-vector ascending/descending mode, and a deterministic tie-break.
- Keys arrive precomputed, with no vertex-matrix lookup inside the block. It sits between the edge-fetch logic and the relaxation engine.

---
 rtl/sort_pipe.sv | 152 +++++++++++++++
 tb/tb_sort_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_pipe.sv
// sort_pipe: pipelined bitonic sorting network for N (key, tag) entries.
// Each register stage holds one network column; the pipeline stalls as a whole under backpressure.
module sort_pipe #(
  parameter int N     = 8,
  parameter int KEY_W = 32,
  parameter int TAG_W = 8,
  localparam int LG     = $clog2(N),
  localparam int STAGES = LG * (LG + 1) / 2,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*KEY_W-1:0] in_keys,
  input  logic [N*TAG_W-1:0] in_tags,
  input  logic               in_descend,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*KEY_W-1:0] out_keys,
  output logic [N*TAG_W-1:0] out_tags,
  output logic [OCC_W-1:0]   occupancy
);

  localparam int EW = KEY_W + TAG_W;

  // Column s belongs to merge phase p (sorted block size 2^(p+1)) and
  // compares entries 2^q apart; columns are enumerated p-major, q descending.
  function automatic int col_phase(input int s);
    int cnt;
    int r;
    cnt = 0;
    r   = 0;
    for (int p = 0; p < LG; p++) begin
      for (int q = p; q >= 0; q--) begin
        if (cnt == s) r = p;
        cnt++;
      end
    end
    return r;
  endfunction

  function automatic int col_dist(input int s);
    int cnt;
    int r;
    cnt = 0;
    r   = 1;
    for (int p = 0; p < LG; p++) begin
      for (int q = p; q >= 0; q--) begin
        if (cnt == s) r = 1 << q;
        cnt++;
      end
    end
    return r;
  endfunction

  // Entries compare on {key, tag}; identical entries never swap.
  function automatic logic need_swap(input logic [EW-1:0] lo, input logic [EW-1:0] hi,
                                     input logic up);
    return up ? (lo > hi) : (lo < hi);
  endfunction

  logic [STAGES-1:0]                      valid_q, valid_d;
  logic [STAGES-1:0]                      desc_q, desc_d;
  logic [STAGES-1:0][N-1:0][KEY_W-1:0]    key_q, key_d;
  logic [STAGES-1:0][N-1:0][TAG_W-1:0]    tag_q, tag_d;
  logic [OCC_W-1:0]                       occ_q, occ_d;

  logic                                   col_v;
  logic                                   col_desc;
  logic [N-1:0][KEY_W-1:0]                col_k;
  logic [N-1:0][TAG_W-1:0]                col_t;

  logic advance;
  logic accept;
  logic retire;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends combinationally on out_ready: the whole pipe moves
  // one step whenever the last stage is empty or being drained.
  assign advance  = !valid_q[STAGES-1] || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign retire   = valid_q[STAGES-1] && out_ready;

  always_comb begin
    valid_d  = valid_q;
    desc_d   = desc_q;
    key_d    = key_q;
    tag_d    = tag_q;
    col_v    = in_valid;
    col_desc = in_descend;
    col_k    = in_keys;
    col_t    = in_tags;
    if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_d[s] = col_v;
        desc_d[s]  = col_desc;
        key_d[s]   = col_k;
        tag_d[s]   = col_t;
        for (int i = 0; i < N; i++) begin
          if ((i & col_dist(s)) == 0) begin
            if (need_swap({col_k[i], col_t[i]},
                          {col_k[i | col_dist(s)], col_t[i | col_dist(s)]},
                          ((((i >> (col_phase(s) + 1)) & 1) == 0) ^ col_desc))) begin
              key_d[s][i]                = col_k[i | col_dist(s)];
              key_d[s][i | col_dist(s)]  = col_k[i];
              tag_d[s][i]                = col_t[i | col_dist(s)];
              tag_d[s][i | col_dist(s)]  = col_t[i];
            end
          end
        end
        // This stage's current contents feed the next column.
        col_v    = valid_q[s];
        col_desc = desc_q[s];
        col_k    = key_q[s];
        col_t    = tag_q[s];
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (accept && !retire) begin
      occ_d = occ_q + 1'b1;
    end else if (!accept && retire) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      desc_q  <= '0;
      key_q   <= '0;
      tag_q   <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      desc_q  <= desc_d;
      key_q   <= key_d;
      tag_q   <= tag_d;
      occ_q   <= occ_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_keys  = key_q[STAGES-1];
  assign out_tags  = tag_q[STAGES-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_sort_pipe.sv
// tb_sort_pipe: directed checks of sort_pipe at N=4 and N=8, including a
// stalled stream against an independent reference sort and a mid-stream reset.
module tb_sort_pipe;

  localparam int KW = 32;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic            in_valid4, in_ready4, in_desc4, out_valid4, out_ready4;
  logic [4*KW-1:0] in_keys4, out_keys4;
  logic [4*TW-1:0] in_tags4, out_tags4;
  logic [1:0]      occ4;

  logic            in_valid8, in_ready8, in_desc8, out_valid8, out_ready8;
  logic [8*KW-1:0] in_keys8, out_keys8;
  logic [8*TW-1:0] in_tags8, out_tags8;
  logic [2:0]      occ8;

  sort_pipe #(.N(4), .KEY_W(KW), .TAG_W(TW)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_keys(in_keys4), .in_tags(in_tags4),
    .in_descend(in_desc4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_keys(out_keys4), .out_tags(out_tags4), .occupancy(occ4)
  );

  sort_pipe #(.N(8), .KEY_W(KW), .TAG_W(TW)) u_dut8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_keys(in_keys8), .in_tags(in_tags8),
    .in_descend(in_desc8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_keys(out_keys8), .out_tags(out_tags8), .occupancy(occ8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*KW-1:0] k4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [4*TW-1:0] t4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Drive one N=4 vector and expect it on the output exactly 3 cycles later, for one cycle.
  task automatic run4(input string name, input logic [4*KW-1:0] k, input logic [4*TW-1:0] t,
                      input logic desc, input logic [4*KW-1:0] ek, input logic [4*TW-1:0] et);
    in_valid4 = 1'b1;
    in_keys4  = k;
    in_tags4  = t;
    in_desc4  = desc;
    @(negedge clk);
    in_valid4 = 1'b0;
    check({name, "_v_c1"}, 256'(out_valid4), 256'(0));
    @(negedge clk);
    check({name, "_v_c2"}, 256'(out_valid4), 256'(0));
    @(negedge clk);
    check({name, "_v_c3"}, 256'(out_valid4), 256'(1));
    check({name, "_keys"}, 256'(out_keys4), 256'(ek));
    check({name, "_tags"}, 256'(out_tags4), 256'(et));
    @(negedge clk);
    check({name, "_v_c4"}, 256'(out_valid4), 256'(0));
    check({name, "_occ"}, 256'(occ4), 256'(0));
  endtask

  task automatic make_vec(input int v, output logic [8*KW-1:0] k, output logic [8*TW-1:0] t);
    for (int i = 0; i < 8; i++) begin
      k[i*KW +: KW] = 32'((v * 13 + i * 29) % 11);
      t[i*TW +: TW] = 8'(v * 8 + i);
    end
    if (v == 3) begin
      k[0 +: KW]    = 32'hFFFF_FFFF;
      k[5*KW +: KW] = 32'h8000_0000;
    end
  endtask

  // Reference: plain bubble sort on {key, tag}.
  task automatic sort_model(input logic [8*KW-1:0] k, input logic [8*TW-1:0] t, input logic desc,
                            output logic [8*KW-1:0] ek, output logic [8*TW-1:0] et);
    logic [KW+TW-1:0] e[8];
    logic [KW+TW-1:0] tmp;
    for (int i = 0; i < 8; i++) e[i] = {k[i*KW +: KW], t[i*TW +: TW]};
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 7 - a; b++) begin
        if ((!desc && e[b] > e[b+1]) || (desc && e[b] < e[b+1])) begin
          tmp = e[b]; e[b] = e[b+1]; e[b+1] = tmp;
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      ek[i*KW +: KW] = e[i][KW+TW-1:TW];
      et[i*TW +: TW] = e[i][TW-1:0];
    end
  endtask

  logic [8*KW-1:0] exp_k_q[$];
  logic [8*TW-1:0] exp_t_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*KW-1:0] vk, ek, held_k, pk;
    logic [8*TW-1:0] vt, et, held_t, pt;
    logic            held, saw_full;
    int              sent, rcvd;

    reset_n    = 1'b0;
    in_valid4  = 1'b0; in_keys4 = '0; in_tags4 = '0; in_desc4 = 1'b0; out_ready4 = 1'b1;
    in_valid8  = 1'b0; in_keys8 = '0; in_tags8 = '0; in_desc8 = 1'b0; out_ready8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid4", 256'(out_valid4), 256'(0));
    check("rst_out_keys4", 256'(out_keys4), 256'(0));
    check("rst_out_tags4", 256'(out_tags4), 256'(0));
    check("rst_occ4", 256'(occ4), 256'(0));
    check("rst_in_ready4", 256'(in_ready4), 256'(1));
    check("rst_out_valid8", 256'(out_valid8), 256'(0));
    check("rst_out_keys8", 256'(out_keys8), 256'(0));
    check("rst_occ8", 256'(occ8), 256'(0));
    reset_n = 1'b1;
    @(negedge clk);

    run4("asc", k4(9, 3, 7, 1), t4(0, 1, 2, 3), 1'b0, k4(1, 3, 7, 9), t4(3, 1, 2, 0));

    // Back-to-back ascending then descending vector.
    in_valid4 = 1'b1; in_keys4 = k4(9, 3, 7, 1); in_tags4 = t4(0, 1, 2, 3); in_desc4 = 1'b0;
    @(negedge clk);
    in_desc4 = 1'b1;
    check("b2b_occ1", 256'(occ4), 256'(1));
    @(negedge clk);
    in_valid4 = 1'b0; in_desc4 = 1'b0;
    check("b2b_occ2", 256'(occ4), 256'(2));
    check("b2b_v_early", 256'(out_valid4), 256'(0));
    @(negedge clk);
    check("b2b_v_a", 256'(out_valid4), 256'(1));
    check("b2b_keys_a", 256'(out_keys4), 256'(k4(1, 3, 7, 9)));
    check("b2b_tags_a", 256'(out_tags4), 256'(t4(3, 1, 2, 0)));
    check("b2b_occ_peak", 256'(occ4), 256'(2));
    @(negedge clk);
    check("b2b_v_b", 256'(out_valid4), 256'(1));
    check("b2b_keys_b", 256'(out_keys4), 256'(k4(9, 7, 3, 1)));
    check("b2b_tags_b", 256'(out_tags4), 256'(t4(0, 2, 1, 3)));
    check("b2b_occ_drain", 256'(occ4), 256'(1));
    @(negedge clk);
    check("b2b_v_end", 256'(out_valid4), 256'(0));
    check("b2b_occ_end", 256'(occ4), 256'(0));

    run4("ties", k4(5, 5, 5, 2), t4(3, 0, 2, 1), 1'b0, k4(2, 5, 5, 5), t4(1, 0, 2, 3));
    run4("ext_asc", k4(32'hFFFF_FFFF, 0, 32'h8000_0000, 1), t4(0, 1, 2, 3), 1'b0,
         k4(0, 1, 32'h8000_0000, 32'hFFFF_FFFF), t4(1, 3, 2, 0));
    run4("ext_desc", k4(32'hFFFF_FFFF, 0, 32'h8000_0000, 1), t4(0, 1, 2, 3), 1'b1,
         k4(32'hFFFF_FFFF, 32'h8000_0000, 1, 0), t4(0, 2, 3, 1));

    // Mid-stream reset with three vectors in flight.
    in_valid4 = 1'b1; in_desc4 = 1'b0;
    in_keys4 = k4(4, 3, 2, 1); in_tags4 = t4(0, 1, 2, 3);
    @(negedge clk);
    in_keys4 = k4(8, 6, 7, 5);
    @(negedge clk);
    in_keys4 = k4(1, 1, 2, 2);
    @(negedge clk);
    in_valid4 = 1'b0;
    check("mid_occ_pre", 256'(occ4), 256'(3));
    check("mid_v_pre", 256'(out_valid4), 256'(1));
    reset_n = 1'b0;
    #1;
    check("mid_v_rst", 256'(out_valid4), 256'(0));
    check("mid_occ_rst", 256'(occ4), 256'(0));
    check("mid_keys_rst", 256'(out_keys4), 256'(0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid_no_stale", 256'(out_valid4), 256'(0));
    end
    run4("post_rst", k4(30, 10, 40, 20), t4(7, 6, 5, 4), 1'b0, k4(10, 20, 30, 40), t4(6, 4, 7, 5));

    // N=8 stream of 10 vectors, alternating mode, with a 6-cycle output stall.
    sent = 0; rcvd = 0; held = 1'b0; saw_full = 1'b0;
    held_k = '0; held_t = '0;
    for (int c = 0; c < 60 && rcvd < 10; c++) begin
      out_ready8 = !(c >= 4 && c <= 9);
      if (sent < 10) begin
        make_vec(sent, vk, vt);
        in_valid8 = 1'b1; in_keys8 = vk; in_tags8 = vt; in_desc8 = sent[0];
      end else begin
        in_valid8 = 1'b0;
      end
      #1;
      if (held) begin
        check("stall_keys_stable", 256'(out_keys8), 256'(held_k));
        check("stall_tags_stable", 256'(out_tags8), 256'(held_t));
        check("stall_valid_held", 256'(out_valid8), 256'(1));
      end
      held   = out_valid8 && !out_ready8;
      held_k = out_keys8;
      held_t = out_tags8;
      if (occ8 == 3'd6 && !out_ready8) begin
        saw_full = 1'b1;
        check("full_in_ready", 256'(in_ready8), 256'(0));
      end
      if (c == 11) check("release_occ", 256'(occ8), 256'(6));
      if (out_valid8 && out_ready8) begin
        if (exp_k_q.size() == 0) begin
          check("stream_unexpected", 256'(out_valid8), 256'(0));
        end else begin
          pk = exp_k_q.pop_front();
          pt = exp_t_q.pop_front();
          check("stream_keys", 256'(out_keys8), 256'(pk));
          check("stream_tags", 256'(out_tags8), 256'(pt));
        end
        rcvd++;
      end
      if (in_valid8 && in_ready8) begin
        sort_model(in_keys8, in_tags8, in_desc8, ek, et);
        exp_k_q.push_back(ek);
        exp_t_q.push_back(et);
        sent++;
      end
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    check("stream_rcvd", 256'(rcvd), 256'(10));
    check("stream_sent", 256'(sent), 256'(10));
    check("stream_saw_full", 256'(saw_full), 256'(1));
    check("stream_queue_empty", 256'(exp_k_q.size()), 256'(0));
    @(negedge clk);
    check("stream_occ_end", 256'(occ8), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
